// File: rtl/load_store_unit.sv
// RV32I load/store unit: aligns and extends loads, and performs sub-word stores as a
// read-modify-write against a word-organised data memory that has a one-cycle registered read.
module load_store_unit (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        illegal,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write_enable,
  output logic        mem_read_enable,
  input  logic [31:0] mem_read_data
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] LOAD_WAIT = 2'd1;
  localparam logic [1:0] RMW_WAIT  = 2'd2;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  logic [1:0]  state_q, state_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  lane_q, lane_d;
  logic [29:0] word_addr_q, word_addr_d;
  logic [15:0] wdata_q, wdata_d;

  logic is_illegal;
  logic is_misaligned;

  // Pick the addressed byte/halfword out of a memory word and extend it to 32 bits.
  function automatic logic [31:0] extract_load(input logic [2:0] f3, input logic [1:0] lane,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*lane +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    extract_load = {{24{b[7]}}, b};
      F3_BU:   extract_load = {24'h0, b};
      F3_H:    extract_load = {{16{h[15]}}, h};
      F3_HU:   extract_load = {16'h0, h};
      default: extract_load = word;
    endcase
  endfunction

  function automatic logic [31:0] merge_store(input logic [2:0] f3, input logic [1:0] lane,
                                              input logic [31:0] word, input logic [15:0] wd);
    merge_store = word;
    case (f3)
      F3_B:    merge_store[8*lane +: 8] = wd[7:0];
      F3_H:    merge_store[16*lane[1] +: 16] = wd;
      default: merge_store = word;
    endcase
  endfunction

  always_comb begin
    if (req_write) begin
      is_illegal = !(req_funct3 inside {F3_B, F3_H, F3_W});
    end else begin
      is_illegal = !(req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    end
    is_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
  end

  always_comb begin
    // NOTE: every output and next-state value gets a default first so no path leaves it unassigned and infers a latch.
    state_d          = state_q;
    funct3_d         = funct3_q;
    lane_d           = lane_q;
    word_addr_d      = word_addr_q;
    wdata_d          = wdata_q;
    stall            = 1'b0;
    load_valid       = 1'b0;
    load_data        = 32'h0;
    misaligned       = 1'b0;
    illegal          = 1'b0;
    mem_address      = 32'h0;
    mem_write_data   = 32'h0;
    mem_write_enable = 1'b0;
    mem_read_enable  = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (is_illegal) begin
            illegal = 1'b1;
          end else if (is_misaligned) begin
            misaligned = 1'b1;
          end else if (req_write && (req_funct3 == F3_W)) begin
            mem_write_enable = 1'b1;
            mem_address      = {req_addr[31:2], 2'b00};
            mem_write_data   = req_wdata;
          end else begin
            // Loads and sub-word stores both start with a word read.
            mem_read_enable = 1'b1;
            mem_address     = {req_addr[31:2], 2'b00};
            stall           = 1'b1;
            funct3_d        = req_funct3;
            lane_d          = req_addr[1:0];
            if (req_write) begin
              word_addr_d = req_addr[31:2];
              wdata_d     = req_wdata[15:0];
              state_d     = RMW_WAIT;
            end else begin
              state_d     = LOAD_WAIT;
            end
          end
        end
      end
      LOAD_WAIT: begin
        load_valid = 1'b1;
        load_data  = extract_load(funct3_q, lane_q, mem_read_data);
        state_d    = IDLE;
      end
      RMW_WAIT: begin
        mem_write_enable = 1'b1;
        mem_address      = {word_addr_q, 2'b00};
        mem_write_data   = merge_store(funct3_q, lane_q, mem_read_data, wdata_q);
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are combinational, so reset must mask them directly to take effect at once.
    if (!reset_n) begin
      stall            = 1'b0;
      load_valid       = 1'b0;
      load_data        = 32'h0;
      misaligned       = 1'b0;
      illegal          = 1'b0;
      mem_address      = 32'h0;
      mem_write_data   = 32'h0;
      mem_write_enable = 1'b0;
      mem_read_enable  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      funct3_q    <= 3'b000;
      lane_q      <= 2'b00;
      word_addr_q <= 30'h0;
      wdata_q     <= 16'h0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      state_q     <= state_d;
      funct3_q    <= funct3_d;
      lane_q      <= lane_d;
      word_addr_q <= word_addr_d;
      wdata_q     <= wdata_d;
    end
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have no parameters: fixed 32-bit data and address, byte-addressed, word-organised data memory with one-cycle registered read.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset; ports are listed in REQ-003 to REQ-018.
REQ-003 clock  in  1  single clock; all state updates on rising edge.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 req_valid  in  1  core memory request present this cycle; held by the core while stall=1.
REQ-006 req_write  in  1  1=store, 0=load.
REQ-007 req_funct3  in  3  RV32I width code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-008 req_addr  in  32  byte address.
REQ-009 req_wdata  in  32  store data, right-aligned.
REQ-010 stall  out  1  core must hold its request and PC this cycle.
REQ-011 load_valid  out  1  load_data valid this cycle.
REQ-012 load_data  out  32  aligned, extended load result.
REQ-013 misaligned  out  1  one-cycle pulse: request dropped for misalignment.
REQ-014 illegal  out  1  one-cycle pulse: request dropped for unsupported funct3.
REQ-015 mem_address  out  32  word-aligned address to data memory (bits [1:0]=00).
REQ-016 mem_write_data  out  32  full word to data memory.
REQ-017 mem_write_enable, mem_read_enable  out  1 each  data memory strobes.
REQ-018 mem_read_data  in  32  data memory read word, valid the cycle after mem_read_enable.

Function
REQ-019 FSM states SHALL be IDLE, LOAD_WAIT, RMW_WAIT; all outputs not driven per REQ-020 to REQ-027 SHALL be 0.
REQ-020 Legal: loads 000,001,010,100,101; stores 000,001,010; any other code in IDLE with req_valid SHALL pulse illegal, make no memory access, no stall, stay IDLE.
REQ-021 Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=00; in IDLE with req_valid SHALL pulse misaligned, make no access, no stall, stay IDLE. Illegal takes priority over misaligned.
REQ-022 SW in IDLE: mem_write_enable=1, mem_address={addr[31:2],00}, mem_write_data=req_wdata, stall=0, stay IDLE (1 cycle).
REQ-023 Load in IDLE: mem_read_enable=1, aligned mem_address, stall=1; latch funct3 and addr[1:0]; go to LOAD_WAIT.
REQ-024 LOAD_WAIT: stall=0, load_valid=1, load_data extracted from mem_read_data by latched fields (byte lane addr[1:0], halfword lane addr[1]; B/H sign-extend, BU/HU zero-extend); go to IDLE. Total load latency 2 cycles.
REQ-025 SB/SH in IDLE: mem_read_enable=1, aligned mem_address, stall=1; latch word address, lane, funct3, wdata; go to RMW_WAIT.
REQ-026 RMW_WAIT: mem_write_enable=1, mem_address=latched, mem_write_data=mem_read_data with selected byte/halfword lane replaced by wdata[7:0]/[15:0]; stall=0; go to IDLE. Total 2 cycles.
REQ-027 Core inputs SHALL be ignored in LOAD_WAIT/RMW_WAIT; a started operation always completes even if req_valid drops.
REQ-028 No address range check: out-of-range loads return memory's 0, out-of-range stores are dropped by memory; block behaviour unchanged.
REQ-029 load_valid, misaligned, illegal SHALL never assert in the same cycle.

Reset
REQ-030 reset_n=0 SHALL immediately force state IDLE, all latched registers 0, all outputs 0 (stall, load_valid, misaligned, illegal, both memory enables, mem_address, mem_write_data, load_data).
REQ-031 Reset in LOAD_WAIT or RMW_WAIT SHALL abandon the operation; no memory write occurs.
REQ-032 First request accepted on the first rising edge after reset_n rises.

Verification
REQ-033 SW addr 0x10 data 0xDEADBEEF -> 1 cycle, mem_write_enable=1, mem_address=0x10, stall=0; then LW 0x10 -> stall 1 cycle, next cycle load_valid=1, load_data=0xDEADBEEF.
REQ-034 SB addr 0x13 data 0x000000A5 -> word 0x10 becomes 0xA5ADBEEF; LB 0x13 -> 0xFFFFFFA5; LBU 0x13 -> 0x000000A5.
REQ-035 SH addr 0x12 data 0x00001234 -> word 0x1234BEEF; LH 0x12 -> 0x00001234; LH 0x10 -> 0xFFFFBEEF; LHU 0x10 -> 0x0000BEEF.
REQ-036 LW 0x11 -> misaligned=1 one cycle, stall=0, both mem enables 0; funct3=011 load -> illegal=1, no access.
REQ-037 SB 0x10 data 0xFF, reset_n=0 during RMW_WAIT -> stall=0 immediately, mem_write_enable=0, word 0x10 unchanged.
REQ-038 LW 0x00002000 -> 2-cycle load, load_data=0x00000000.
